// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Byte FIFO between uart_rx (upstream) and ram_rw (downstream) on sys_clk.
// It absorbs host bursts while ram_rw is busy. The read side is
// first-word-fall-through: the head entry is visible whenever it is valid.
//
// Ports
//   clk_i           sys_clk; all state changes on the rising edge
//   rst_i           synchronous active-high reset
//   fifo_flush_i    synchronous clear of contents; same effect as rst_i
//   fifo_wr_data_i  write data
//   fifo_wr_vld_i   write valid
//   fifo_wr_rdy_o   write ready; high when the FIFO is not full
//   fifo_rd_data_o  head entry; zero when the FIFO is empty
//   fifo_rd_vld_o   head valid; high when the FIFO is not empty
//   fifo_rd_rdy_i   read ready
//   fifo_level_o    current occupancy, 0..DEPTH
//   fifo_afull_o    high when level >= AFULL_THRESH
//   fifo_ovf_o      sticky flag: a write was attempted while full
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = 16,
    parameter int AFULL_THRESH = 12
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       fifo_flush_i,
    input  logic [DATA_WIDTH-1:0]      fifo_wr_data_i,
    input  logic                       fifo_wr_vld_i,
    output logic                       fifo_wr_rdy_o,
    output logic [DATA_WIDTH-1:0]      fifo_rd_data_o,
    output logic                       fifo_rd_vld_o,
    input  logic                       fifo_rd_rdy_i,
    output logic [$clog2(DEPTH):0]     fifo_level_o,
    output logic                       fifo_afull_o,
    output logic                       fifo_ovf_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_AFULL = LW'(AFULL_THRESH);
    localparam logic [LW-1:0] LVL_ONE   = LW'(1);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q,  level_d;
    logic          ovf_q,    ovf_d;

    logic full_s;
    logic empty_s;
    logic wr_en_s;
    logic rd_en_s;

    // Status decoded from the registered level only, so wr_rdy never depends
    // on the read side within the same cycle.
    assign full_s  = (level_q == LVL_FULL);
    assign empty_s = (level_q == {LW{1'b0}});

    // A flush cycle discards any handshake; reset is handled in the register.
    assign wr_en_s = fifo_wr_vld_i & ~full_s  & ~fifo_flush_i & ~rst_i;
    assign rd_en_s = fifo_rd_rdy_i & ~empty_s & ~fifo_flush_i & ~rst_i;

    assign fifo_wr_rdy_o  = ~full_s;
    assign fifo_rd_vld_o  = ~empty_s;
    assign fifo_rd_data_o = empty_s ? {DATA_WIDTH{1'b0}} : mem_q[rd_ptr_q];
    assign fifo_level_o   = level_q;
    assign fifo_afull_o   = (level_q >= LVL_AFULL);
    assign fifo_ovf_o     = ovf_q;

    // Next-state for pointers, occupancy and the sticky overflow flag.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        if (fifo_flush_i) begin
            wr_ptr_d = {PW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
            level_d  = {LW{1'b0}};
            ovf_d    = 1'b0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (rd_en_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            // Simultaneous write and read leave the level unchanged.
            case ({wr_en_s, rd_en_s})
                2'b10:   level_d = level_q + LVL_ONE;
                2'b01:   level_d = level_q - LVL_ONE;
                default: level_d = level_q;
            endcase
            if (fifo_wr_vld_i && full_s) begin
                ovf_d = 1'b1;
            end else begin
                ovf_d = ovf_q;
            end
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            level_q  <= {LW{1'b0}};
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage array; contents are deliberately left unreset.
    always_ff @(posedge clk_i) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= fifo_wr_data_i;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [7:0] wr_data;
    logic       wr_vld;
    logic       wr_rdy;
    logic [7:0] rd_data;
    logic       rd_vld;
    logic       rd_rdy;
    logic [4:0] level;
    logic       afull;
    logic       ovf;

    int errors = 0;
    int checks = 0;

    uart_rx_fifo #(.DATA_WIDTH(8), .DEPTH(16), .AFULL_THRESH(12)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .fifo_flush_i   (flush),
        .fifo_wr_data_i (wr_data),
        .fifo_wr_vld_i  (wr_vld),
        .fifo_wr_rdy_o  (wr_rdy),
        .fifo_rd_data_o (rd_data),
        .fifo_rd_vld_o  (rd_vld),
        .fifo_rd_rdy_i  (rd_rdy),
        .fifo_level_o   (level),
        .fifo_afull_o   (afull),
        .fifo_ovf_o     (ovf)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; inputs are then changed and outputs sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; wr_vld = 1'b0; rd_rdy = 1'b0; wr_data = 8'h00;
        step(); step();
        rst = 1'b0;
        checks++; if (wr_rdy !== 1'b1) begin errors++; $display("FAIL reset_wr_rdy got=%b exp=1", wr_rdy); end
        checks++; if (rd_vld !== 1'b0) begin errors++; $display("FAIL reset_rd_vld got=%b exp=0", rd_vld); end
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got=%h exp=00", rd_data); end
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++; if (afull !== 1'b0) begin errors++; $display("FAIL reset_afull got=%b exp=0", afull); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    endtask

    task automatic test_single();
        wr_data = 8'hA5; wr_vld = 1'b1; rd_rdy = 1'b0;
        step();
        wr_vld = 1'b0; wr_data = 8'h00;
        checks++; if (rd_vld !== 1'b1) begin errors++; $display("FAIL single_vld got=%b exp=1", rd_vld); end
        checks++; if (rd_data !== 8'hA5) begin errors++; $display("FAIL single_data got=%h exp=a5", rd_data); end
        checks++; if (level !== 5'd1) begin errors++; $display("FAIL single_level got=%0d exp=1", level); end
        step(); step();
        checks++; if (rd_data !== 8'hA5 || rd_vld !== 1'b1) begin errors++; $display("FAIL single_hold got=%h/%b exp=a5/1", rd_data, rd_vld); end
        rd_rdy = 1'b1;
        step();
        rd_rdy = 1'b0;
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL single_drain_level got=%0d exp=0", level); end
        checks++; if (rd_vld !== 1'b0 || rd_data !== 8'h00) begin errors++; $display("FAIL single_empty got=%h/%b exp=00/0", rd_data, rd_vld); end
    endtask

    task automatic test_fill_ovf();
        for (int i = 0; i < 16; i++) begin
            checks++; if (afull !== (i >= 12)) begin errors++; $display("FAIL fill_afull lvl=%0d got=%b exp=%b", i, afull, (i >= 12)); end
            checks++; if (wr_rdy !== 1'b1) begin errors++; $display("FAIL fill_wr_rdy lvl=%0d got=%b exp=1", i, wr_rdy); end
            wr_data = 8'(i); wr_vld = 1'b1;
            step();
        end
        wr_vld = 1'b0;
        checks++; if (level !== 5'd16) begin errors++; $display("FAIL full_level got=%0d exp=16", level); end
        checks++; if (wr_rdy !== 1'b0) begin errors++; $display("FAIL full_wr_rdy got=%b exp=0", wr_rdy); end
        checks++; if (afull !== 1'b1) begin errors++; $display("FAIL full_afull got=%b exp=1", afull); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL full_ovf_pre got=%b exp=0", ovf); end
        wr_data = 8'hEE; wr_vld = 1'b1;
        step();
        wr_vld = 1'b0;
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", ovf); end
        checks++; if (level !== 5'd16) begin errors++; $display("FAIL ovf_level got=%0d exp=16", level); end
    endtask

    task automatic test_full_wr_rd();
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL full_head got=%h exp=00", rd_data); end
        wr_data = 8'h10; wr_vld = 1'b1; rd_rdy = 1'b1;
        step();
        rd_rdy = 1'b0;
        checks++; if (level !== 5'd15) begin errors++; $display("FAIL full_rw_level got=%0d exp=15", level); end
        checks++; if (rd_data !== 8'h01) begin errors++; $display("FAIL full_rw_head got=%h exp=01", rd_data); end
        step();
        wr_vld = 1'b0;
        checks++; if (level !== 5'd16) begin errors++; $display("FAIL full_rw_refill got=%0d exp=16", level); end
        // Drain: 0x01..0x0F then the retried 0x10; the refused 0xEE never appears.
        rd_rdy = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            checks++; if (rd_data !== 8'(i) || rd_vld !== 1'b1) begin errors++; $display("FAIL drain_order idx=%0d got=%h exp=%h", i, rd_data, 8'(i)); end
            step();
        end
        rd_rdy = 1'b0;
        checks++; if (level !== 5'd0 || rd_vld !== 1'b0) begin errors++; $display("FAIL drain_empty got=%0d/%b exp=0/0", level, rd_vld); end
    endtask

    task automatic test_back_to_back();
        rd_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr_data = 8'h20 + 8'(i); wr_vld = 1'b1;
            step();
        end
        wr_vld = 1'b0;
        checks++; if (level !== 5'd3) begin errors++; $display("FAIL b2b_prefill got=%0d exp=3", level); end
        for (int k = 0; k < 40; k++) begin
            wr_data = 8'h23 + 8'(k); wr_vld = 1'b1; rd_rdy = 1'b1;
            checks++; if (rd_data !== 8'h20 + 8'(k)) begin errors++; $display("FAIL b2b_order k=%0d got=%h exp=%h", k, rd_data, 8'h20 + 8'(k)); end
            step();
            checks++; if (level !== 5'd3) begin errors++; $display("FAIL b2b_level k=%0d got=%0d exp=3", k, level); end
        end
        wr_vld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (rd_data !== 8'h48 + 8'(i)) begin errors++; $display("FAIL b2b_tail i=%0d got=%h exp=%h", i, rd_data, 8'h48 + 8'(i)); end
            step();
        end
        rd_rdy = 1'b0;
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL b2b_empty got=%0d exp=0", level); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 7; i++) begin
            wr_data = 8'h60 + 8'(i); wr_vld = 1'b1;
            step();
        end
        checks++; if (level !== 5'd7 || ovf !== 1'b1) begin errors++; $display("FAIL flush_pre got=%0d/%b exp=7/1", level, ovf); end
        wr_data = 8'h5A; wr_vld = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0; wr_vld = 1'b0;
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL flush_level got=%0d exp=0", level); end
        checks++; if (rd_vld !== 1'b0) begin errors++; $display("FAIL flush_rd_vld got=%b exp=0", rd_vld); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL flush_ovf got=%b exp=0", ovf); end
        checks++; if (wr_rdy !== 1'b1) begin errors++; $display("FAIL flush_wr_rdy got=%b exp=1", wr_rdy); end
        wr_data = 8'h77; wr_vld = 1'b1;
        step();
        wr_vld = 1'b0;
        checks++; if (rd_data !== 8'h77 || level !== 5'd1) begin errors++; $display("FAIL flush_after got=%h/%0d exp=77/1", rd_data, level); end
        // Empty + write + read together: only the write lands.
        rd_rdy = 1'b1;
        step();
        rd_rdy = 1'b0;
        wr_data = 8'h88; wr_vld = 1'b1; rd_rdy = 1'b1;
        step();
        wr_vld = 1'b0; rd_rdy = 1'b0;
        checks++; if (level !== 5'd1 || rd_data !== 8'h88) begin errors++; $display("FAIL empty_wr_rd got=%0d/%h exp=1/88", level, rd_data); end
    endtask

    initial begin
        #1;
        test_reset();
        test_single();
        test_fill_ovf();
        test_full_wr_rd();
        test_back_to_back();
        test_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
